// File: rtl/eqed_inject_ctrl_if.sv
// Request and select-bus signals between a fault-injection sequencer and the
// eqed_inject_ctrl window generator.
interface eqed_inject_ctrl_if #(
    parameter int NUM_FF = 8,
    parameter int IDX_W  = 3,
    parameter int DLY_W  = 16,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 8
) ();
    logic              cfg_valid;
    logic              cfg_ready;
    logic [IDX_W-1:0]  cfg_ff_idx;
    logic [DLY_W-1:0]  cfg_delay;
    logic [LEN_W-1:0]  cfg_len;
    logic              abort;
    logic [NUM_FF-1:0] eqed_sel;
    logic              inj_active;
    logic              inj_done;
    logic              cfg_err;
    logic [CNT_W-1:0]  inj_count;

    modport master (
        output cfg_valid, cfg_ff_idx, cfg_delay, cfg_len, abort,
        input  cfg_ready, eqed_sel, inj_active, inj_done, cfg_err, inj_count
    );

    modport slave (
        input  cfg_valid, cfg_ff_idx, cfg_delay, cfg_len, abort,
        output cfg_ready, eqed_sel, inj_active, inj_done, cfg_err, inj_count
    );
endinterface

// File: rtl/eqed_inject_ctrl.sv
// Cycle-controlled EQED injection window generator: one request at a time drives
// a one-hot eqed_sel pulse after a programmable delay, then reports completion.
module eqed_inject_ctrl #(
    parameter int NUM_FF = 8,
    parameter int IDX_W  = 3,
    parameter int DLY_W  = 16,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    eqed_inject_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_INJECT, S_DONE} state_t;

    localparam logic [IDX_W:0] NUM_FF_W = (IDX_W + 1)'(NUM_FF);

    state_t            state_reg, state_next;
    logic [DLY_W-1:0]  dly_reg, dly_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [NUM_FF-1:0] sel_reg, sel_next;
    logic              active_reg, active_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              ready_reg, ready_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic [IDX_W-1:0]  dec_idx;
    logic [NUM_FF-1:0] dec_onehot;
    logic              accept;
    logic              idx_bad;

    // A zero-delay request enters INJECT straight from IDLE, before idx_reg is
    // loaded, so the decoder looks at the live request index while idle.
    assign dec_idx = (state_reg == S_IDLE) ? bus.cfg_ff_idx : idx_reg;

    generate
        for (genvar gi = 0; gi < NUM_FF; gi++) begin : g_dec
            assign dec_onehot[gi] = (dec_idx == IDX_W'(gi));
        end
    endgenerate

    assign accept  = bus.cfg_valid && ready_reg;
    assign idx_bad = ({1'b0, bus.cfg_ff_idx} >= NUM_FF_W);

    always_comb begin
        state_next = state_reg;
        dly_next   = dly_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        sel_next   = '0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        count_next = count_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (idx_bad) begin
                        err_next = 1'b1;
                    end else begin
                        idx_next = bus.cfg_ff_idx;
                        len_next = (bus.cfg_len == '0) ? LEN_W'(1) : bus.cfg_len;
                        if (bus.cfg_delay == '0) begin
                            state_next = S_INJECT;
                            sel_next   = dec_onehot;
                        end else begin
                            dly_next   = bus.cfg_delay;
                            state_next = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (bus.abort) begin
                    state_next = S_IDLE;
                end else if (dly_reg == DLY_W'(1)) begin
                    state_next = S_INJECT;
                    sel_next   = dec_onehot;
                end else begin
                    dly_next = dly_reg - DLY_W'(1);
                end
            end
            S_INJECT: begin
                if (bus.abort) begin
                    state_next = S_IDLE;
                end else if (len_reg == LEN_W'(1)) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                    if (count_reg != '1)
                        count_next = count_reg + CNT_W'(1);
                end else begin
                    len_next = len_reg - LEN_W'(1);
                    sel_next = dec_onehot;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        ready_next  = (state_next == S_IDLE);
        active_next = |sel_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            dly_reg    <= '0;
            len_reg    <= '0;
            idx_reg    <= '0;
            sel_reg    <= '0;
            active_reg <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            ready_reg  <= 1'b1;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            dly_reg    <= dly_next;
            len_reg    <= len_next;
            idx_reg    <= idx_next;
            sel_reg    <= sel_next;
            active_reg <= active_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            ready_reg  <= ready_next;
            count_reg  <= count_next;
        end
    end

    assign bus.eqed_sel   = sel_reg;
    assign bus.inj_active = active_reg;
    assign bus.inj_done   = done_reg;
    assign bus.cfg_err    = err_reg;
    assign bus.cfg_ready  = ready_reg;
    assign bus.inj_count  = count_reg;
endmodule

// File: tb/tb_eqed_inject_ctrl.sv
// Directed bench for eqed_inject_ctrl: three instances (default, NUM_FF=6,
// CNT_W=2) exercised one after another with hand-computed expectations.
module tb_eqed_inject_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    eqed_inject_ctrl_if #(.NUM_FF(8), .IDX_W(3), .DLY_W(16), .LEN_W(4), .CNT_W(8)) a_if ();
    eqed_inject_ctrl_if #(.NUM_FF(6), .IDX_W(3), .DLY_W(16), .LEN_W(4), .CNT_W(8)) b_if ();
    eqed_inject_ctrl_if #(.NUM_FF(8), .IDX_W(3), .DLY_W(16), .LEN_W(4), .CNT_W(2)) c_if ();

    eqed_inject_ctrl #(.NUM_FF(8), .IDX_W(3), .DLY_W(16), .LEN_W(4), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .bus(a_if.slave));
    eqed_inject_ctrl #(.NUM_FF(6), .IDX_W(3), .DLY_W(16), .LEN_W(4), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .bus(b_if.slave));
    eqed_inject_ctrl #(.NUM_FF(8), .IDX_W(3), .DLY_W(16), .LEN_W(4), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .bus(c_if.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge: outputs now show the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {a_if.cfg_valid, a_if.abort, b_if.cfg_valid, b_if.abort, c_if.cfg_valid, c_if.abort} = '0;
        a_if.cfg_ff_idx = '0; a_if.cfg_delay = '0; a_if.cfg_len = '0;
        b_if.cfg_ff_idx = '0; b_if.cfg_delay = '0; b_if.cfg_len = '0;
        c_if.cfg_ff_idx = '0; c_if.cfg_delay = '0; c_if.cfg_len = '0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_sel",    32'(a_if.eqed_sel),   32'h0);
        check("rst_active", 32'(a_if.inj_active), 32'h0);
        check("rst_done",   32'(a_if.inj_done),   32'h0);
        check("rst_err",    32'(a_if.cfg_err),    32'h0);
        check("rst_count",  32'(a_if.inj_count),  32'h0);
        check("rst_ready",  32'(a_if.cfg_ready),  32'h1);

        // T1: idx=2 delay=0 len=1
        a_if.cfg_valid = 1'b1; a_if.cfg_ff_idx = 3'd2; a_if.cfg_delay = 16'd0; a_if.cfg_len = 4'd1;
        step();
        a_if.cfg_valid = 1'b0;
        check("t1_sel_n1",    32'(a_if.eqed_sel),   32'h04);
        check("t1_active_n1", 32'(a_if.inj_active), 32'h1);
        check("t1_ready_n1",  32'(a_if.cfg_ready),  32'h0);
        step();
        check("t1_sel_n2",    32'(a_if.eqed_sel),   32'h00);
        check("t1_done_n2",   32'(a_if.inj_done),   32'h1);
        check("t1_ready_n2",  32'(a_if.cfg_ready),  32'h0);
        step();
        check("t1_ready_n3",  32'(a_if.cfg_ready),  32'h1);
        check("t1_done_n3",   32'(a_if.inj_done),   32'h0);
        check("t1_count",     32'(a_if.inj_count),  32'd1);

        // T2: idx=7 delay=5 len=3, cfg_valid held (different idx) while busy
        a_if.cfg_valid = 1'b1; a_if.cfg_ff_idx = 3'd7; a_if.cfg_delay = 16'd5; a_if.cfg_len = 4'd3;
        step();
        a_if.cfg_ff_idx = 3'd1; a_if.cfg_delay = 16'd0; a_if.cfg_len = 4'd1;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) step();
            check($sformatf("t2_sel_n%0d", k),   32'(a_if.eqed_sel),
                  (k >= 6 && k <= 8) ? 32'h80 : 32'h00);
            check($sformatf("t2_done_n%0d", k),  32'(a_if.inj_done), (k == 9) ? 32'h1 : 32'h0);
            check($sformatf("t2_ready_n%0d", k), 32'(a_if.cfg_ready), 32'h0);
        end
        step();
        a_if.cfg_valid = 1'b0;
        check("t2_ready_n10", 32'(a_if.cfg_ready), 32'h1);
        check("t2_count",     32'(a_if.inj_count), 32'd2);
        step();
        check("t2_no_accept_sel", 32'(a_if.eqed_sel), 32'h00);

        // T3: idx=0 delay=1 len=0 -> single cycle pulse
        a_if.cfg_valid = 1'b1; a_if.cfg_ff_idx = 3'd0; a_if.cfg_delay = 16'd1; a_if.cfg_len = 4'd0;
        step();
        a_if.cfg_valid = 1'b0;
        check("t3_sel_n1", 32'(a_if.eqed_sel), 32'h00);
        step();
        check("t3_sel_n2",    32'(a_if.eqed_sel),   32'h01);
        check("t3_active_n2", 32'(a_if.inj_active), 32'h1);
        step();
        check("t3_sel_n3",  32'(a_if.eqed_sel), 32'h00);
        check("t3_done_n3", 32'(a_if.inj_done), 32'h1);
        step();
        check("t3_count", 32'(a_if.inj_count), 32'd3);

        // T4: idx=3 delay=4 len=8, abort in second INJECT cycle
        a_if.cfg_valid = 1'b1; a_if.cfg_ff_idx = 3'd3; a_if.cfg_delay = 16'd4; a_if.cfg_len = 4'd8;
        step();
        a_if.cfg_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) step();
            check($sformatf("t4_sel_n%0d", k), 32'(a_if.eqed_sel), (k >= 5) ? 32'h08 : 32'h00);
        end
        a_if.abort = 1'b1;
        step();
        a_if.abort = 1'b0;
        check("t4_sel_after_abort",    32'(a_if.eqed_sel),   32'h00);
        check("t4_active_after_abort", 32'(a_if.inj_active), 32'h0);
        check("t4_done_after_abort",   32'(a_if.inj_done),   32'h0);
        step();
        check("t4_ready",   32'(a_if.cfg_ready), 32'h1);
        check("t4_done_n2", 32'(a_if.inj_done),  32'h0);
        check("t4_count",   32'(a_if.inj_count), 32'd3);

        // abort together with a request in IDLE: request wins
        a_if.cfg_valid = 1'b1; a_if.abort = 1'b1;
        a_if.cfg_ff_idx = 3'd5; a_if.cfg_delay = 16'd0; a_if.cfg_len = 4'd2;
        step();
        a_if.cfg_valid = 1'b0; a_if.abort = 1'b0;
        check("idle_abort_sel_n1", 32'(a_if.eqed_sel), 32'h20);
        step();
        check("idle_abort_sel_n2", 32'(a_if.eqed_sel), 32'h20);
        step();
        check("idle_abort_done", 32'(a_if.inj_done), 32'h1);
        step();
        check("idle_abort_count", 32'(a_if.inj_count), 32'd4);

        // T5: NUM_FF=6, out-of-range idx
        b_if.cfg_valid = 1'b1; b_if.cfg_ff_idx = 3'd6; b_if.cfg_delay = 16'd0; b_if.cfg_len = 4'd1;
        step();
        b_if.cfg_valid = 1'b0;
        check("t5_err",   32'(b_if.cfg_err),   32'h1);
        check("t5_sel",   32'(b_if.eqed_sel),  32'h00);
        check("t5_ready", 32'(b_if.cfg_ready), 32'h1);
        step();
        check("t5_err_clear", 32'(b_if.cfg_err),   32'h0);
        check("t5_count",     32'(b_if.inj_count), 32'd0);
        // one good injection so the reset below has a count to clear
        b_if.cfg_valid = 1'b1; b_if.cfg_ff_idx = 3'd4;
        step();
        b_if.cfg_valid = 1'b0;
        check("t5_good_sel", 32'(b_if.eqed_sel), 32'h10);
        step(); step();
        check("t5_good_count", 32'(b_if.inj_count), 32'd1);
        // idx=1 len=10, reset in the third window cycle
        b_if.cfg_valid = 1'b1; b_if.cfg_ff_idx = 3'd1; b_if.cfg_len = 4'd10;
        step();
        b_if.cfg_valid = 1'b0;
        step(); step();
        check("t5_window_sel", 32'(b_if.eqed_sel), 32'h02);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_sel",    32'(b_if.eqed_sel),   32'h00);
        check("t5_rst_active", 32'(b_if.inj_active), 32'h0);
        check("t5_rst_done",   32'(b_if.inj_done),   32'h0);
        check("t5_rst_count",  32'(b_if.inj_count),  32'd0);
        check("t5_rst_ready",  32'(b_if.cfg_ready),  32'h1);
        step();
        check("t5_rst_done_n2", 32'(b_if.inj_done), 32'h0);
        check("t5_rst_sel_n2",  32'(b_if.eqed_sel), 32'h00);

        // T6: CNT_W=2 saturation
        for (int i = 0; i < 5; i++) begin
            c_if.cfg_valid = 1'b1; c_if.cfg_ff_idx = 3'(i); c_if.cfg_delay = 16'd0; c_if.cfg_len = 4'd1;
            step();
            c_if.cfg_valid = 1'b0;
            step(); step();
            check($sformatf("t6_count_%0d", i + 1), 32'(c_if.inj_count),
                  (i >= 2) ? 32'd3 : 32'(i + 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
